// File: rtl/crc_stream_pkg.sv
`default_nettype none
// crc_stream_pkg -- shared FSM state and mode encodings for the streaming CRC engine (rev 1.0)
package crc_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

endpackage
`default_nettype wire

// File: rtl/crc_stream_step.sv
`default_nettype none
// crc_stream_step -- combinational STEP_W-bit MSB-first polynomial division step (rev 1.0)
module crc_stream_step #(
  parameter int                STEP_W = 8,
  parameter int                CRC_BW = 8,
  parameter logic [CRC_BW-1:0] POLY   = 8'h07
) (
  input  logic [CRC_BW-1:0] r_in,
  input  logic [STEP_W-1:0] bits_in,
  output logic [CRC_BW-1:0] r_out
);

  logic [CRC_BW-1:0] acc;

  always_comb begin
    acc = r_in;
    for (int i = STEP_W - 1; i >= 0; i--) begin
      acc = {acc[CRC_BW-2:0], bits_in[i]} ^ (acc[CRC_BW-1] ? POLY : {CRC_BW{1'b0}});
    end
    r_out = acc;
  end

endmodule
`default_nettype wire

// File: rtl/crc_stream_engine.sv
`default_nettype none
// crc_stream_engine -- streaming CRC generate/check over DATA_W-bit beats (rev 1.0)
// Build option: CRC_STREAM_ABORT_EN adds s_abort to drop the frame in progress.
module crc_stream_engine
  import crc_stream_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                CRC_BW = 8,
  parameter logic [CRC_BW-1:0] POLY   = 8'h07
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_mode,
`ifdef CRC_STREAM_ABORT_EN
  input  logic              s_abort,
`endif
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CRC_BW-1:0] m_crc,
  output logic              m_err
);

  state_t            state, state_nxt;
  logic [CRC_BW-1:0] r, r_nxt, r_beat, r_flush;
  logic              mode, mode_nxt;

  crc_stream_step #(
    .STEP_W (DATA_W),
    .CRC_BW (CRC_BW),
    .POLY   (POLY)
  ) u_step_beat (
    .r_in    (r),
    .bits_in (s_data),
    .r_out   (r_beat)
  );

  // Appends the CRC_BW zero bits of generate mode in a single cycle.
  crc_stream_step #(
    .STEP_W (CRC_BW),
    .CRC_BW (CRC_BW),
    .POLY   (POLY)
  ) u_step_flush (
    .r_in    (r),
    .bits_in ({CRC_BW{1'b0}}),
    .r_out   (r_flush)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      mode  <= MODE_GEN;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      mode  <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    mode_nxt  = mode;
    s_ready   = 1'b0;
    m_valid   = 1'b0;

    case (state)
      IDLE: begin
        s_ready = rst_n;
        if (s_valid) begin
          mode_nxt = s_mode;
          r_nxt    = r_beat;
          if (s_last) state_nxt = (s_mode == MODE_CHK) ? OUT : FLUSH;
          else        state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        s_ready = rst_n;
        if (s_valid) begin
          r_nxt = r_beat;
          if (s_last) state_nxt = (mode == MODE_CHK) ? OUT : FLUSH;
        end
      end
      FLUSH: begin
        r_nxt     = r_flush;
        state_nxt = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_nxt = IDLE;
          r_nxt     = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        r_nxt     = '0;
      end
    endcase

`ifdef CRC_STREAM_ABORT_EN
    // Abort wins over any beat accepted this cycle; a pending result is never dropped.
    if (s_abort && (state != OUT)) begin
      state_nxt = IDLE;
      r_nxt     = '0;
    end
`endif
  end

  assign m_crc = (state == OUT) ? r : '0;
  assign m_err = (state == OUT) && (mode == MODE_CHK) && (|r);

endmodule
`default_nettype wire

// File: tb/tb_crc_stream_engine.sv
`default_nettype none
// tb_crc_stream_engine -- directed frames against a frame-level CRC/timing model.
module tb_crc_stream_engine;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_mode = 1'b0;
  logic       s_abort = 1'b0;
  logic       m_ready = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, m_valid, m_err;
  logic [7:0] m_crc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  crc_stream_engine #(
    .DATA_W (8),
    .CRC_BW (8),
    .POLY   (8'h07)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_mode  (s_mode),
`ifdef CRC_STREAM_ABORT_EN
    .s_abort (s_abort),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_crc   (m_crc),
    .m_err   (m_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // CRC defined as long division of the bit stream (plus CRC_BW zero bits in generate mode).
  function automatic logic [7:0] crc_model(input bq_t q, input bit gen);
    logic [7:0] r;
    logic [7:0] b;
    int         n;
    r = 8'h00;
    n = q.size() + (gen ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      b = (i < q.size()) ? q[i] : 8'h00;
      for (int k = 7; k >= 0; k--) begin
        r = {r[6:0], b[k]} ^ (r[7] ? 8'h07 : 8'h00);
      end
    end
    return r;
  endfunction

  // Frame-level model: a result is owed from last-beat acceptance until its handshake.
  bit         busy = 1'b0;
  bit         in_frame = 1'b0;
  bit         fmode = 1'b0;
  bit         want_v;
  logic [7:0] exp_crc = 8'h00;
  bit         exp_err = 1'b0;
  int         due = 0;
  int         last_t = 0;
  bq_t        frame;
  logic [7:0] seen_crc[$];
  bit         seen_err[$];
  int         seen_cyc[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      busy     = 1'b0;
      in_frame = 1'b0;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_crc", m_crc, 0);
      chk("rst_m_err", m_err, 0);
    end else begin
      want_v = busy && (cyc >= due);
      chk("s_ready", s_ready, !busy);
      chk("m_valid", m_valid, want_v);
      if (want_v) begin
        chk("m_crc", m_crc, exp_crc);
        chk("m_err", m_err, exp_err);
      end
      if (want_v && m_ready) begin
        busy = 1'b0;
        seen_crc.push_back(m_crc);
        seen_err.push_back(m_err);
        seen_cyc.push_back(cyc);
      end
`ifdef CRC_STREAM_ABORT_EN
      else if (busy && !want_v && s_abort) begin
        busy = 1'b0;
      end
`endif
      else if (!busy && s_valid) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          fmode    = s_mode;
          frame.delete();
        end
        frame.push_back(s_data);
`ifdef CRC_STREAM_ABORT_EN
        if (s_abort) in_frame = 1'b0;
        else
`endif
        if (s_last) begin
          exp_crc  = crc_model(frame, !fmode);
          exp_err  = fmode && (exp_crc != 8'h00);
          busy     = 1'b1;
          due      = cyc + (fmode ? 1 : 2);
          in_frame = 1'b0;
          last_t   = cyc;
        end
      end
    end
  end

  int last_wait = 0;
  int first_wait = 0;

  task automatic send_beat(input logic [7:0] d, input bit last, input bit mode);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_mode  = mode;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    last_wait = n;
    if (!ok) timeout("beat_accept");
  endtask

  task automatic send_frame(input bq_t q, input bit mode, input bit hold);
    for (int i = 0; i < q.size(); i++) begin
      send_beat(q[i], i == q.size() - 1, mode);
      if (i == 0) first_wait = last_wait;
    end
    if (!hold) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic wait_seen(input int n);
    int k;
    k = 0;
    while (seen_crc.size() < n && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (seen_crc.size() < n) timeout("result_wait");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_m_valid();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_valid && k < 20);
    if (!m_valid) timeout("m_valid_wait");
  endtask

  task automatic expect_result(input string name, input int idx, input logic [7:0] crc,
                               input bit err, input int lat);
    if (idx >= seen_crc.size()) begin
      timeout(name);
    end else begin
      chk({name, "_crc"}, seen_crc[idx], crc);
      chk({name, "_err"}, seen_err[idx], err);
      if (lat > 0) chk({name, "_lat"}, seen_cyc[idx] - last_t, lat);
    end
  endtask

  initial begin
    bq_t q9, q10, q10b, q1, q0;
    int  base;
    q9   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    q10  = q9;
    q10.push_back(8'hF4);
    q10b = q9;
    q10b.push_back(8'hF5);
    q1   = '{8'h01};
    q0   = '{8'h00};

    // Pin the model to known CRC-8 values.
    chk("model_gen9", crc_model(q9, 1'b1), 8'hF4);
    chk("model_gen01", crc_model(q1, 1'b1), 8'h07);
    chk("model_chk_f5", crc_model(q10b, 1'b0), 8'h01);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    base = seen_crc.size();
    send_frame(q9, 1'b0, 1'b0);
    wait_seen(base + 1);
    expect_result("gen9", base, 8'hF4, 1'b0, 2);

    base = seen_crc.size();
    send_frame(q10, 1'b1, 1'b0);
    wait_seen(base + 1);
    expect_result("chk_good", base, 8'h00, 1'b0, 1);

    base = seen_crc.size();
    send_frame(q10b, 1'b1, 1'b0);
    wait_seen(base + 1);
    expect_result("chk_bad", base, 8'h01, 1'b1, 1);

    base = seen_crc.size();
    send_frame(q1, 1'b0, 1'b0);
    wait_seen(base + 1);
    expect_result("gen_01", base, 8'h07, 1'b0, 2);

    base = seen_crc.size();
    send_frame(q0, 1'b0, 1'b0);
    wait_seen(base + 1);
    expect_result("gen_00", base, 8'h00, 1'b0, 2);

    // Back-to-back frames with s_valid held across FLUSH/OUT.
    base = seen_crc.size();
    send_frame(q1, 1'b0, 1'b1);
    send_frame(q10b, 1'b1, 1'b1);
    send_frame(q9, 1'b0, 1'b0);
    wait_seen(base + 3);
    expect_result("b2b_0", base, 8'h07, 1'b0, 0);
    expect_result("b2b_1", base + 1, 8'h01, 1'b1, 0);
    expect_result("b2b_2", base + 2, 8'hF4, 1'b0, 2);

    // Output backpressure.
    base = seen_crc.size();
    m_ready = 1'b0;
    send_frame(q1, 1'b0, 1'b0);
    wait_m_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_crc", m_crc, 8'h07);
      chk("bp_s_ready", s_ready, 0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send_frame(q9, 1'b0, 1'b0);
    chk("bp_next_accept_wait", first_wait, 2);
    wait_seen(base + 2);
    expect_result("bp_0", base, 8'h07, 1'b0, 0);
    expect_result("bp_1", base + 1, 8'hF4, 1'b0, 2);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 4; i++) send_beat(q9[i], 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_frame_s_ready", s_ready, 0);
    chk("arst_frame_m_valid", m_valid, 0);
    s_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset while a result is held.
    m_ready = 1'b0;
    send_frame(q1, 1'b0, 1'b0);
    wait_m_valid();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_m_valid", m_valid, 0);
    chk("arst_out_m_crc", m_crc, 0);
    chk("arst_out_s_ready", s_ready, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    base = seen_crc.size();
    send_frame(q9, 1'b0, 1'b0);
    wait_seen(base + 1);
    expect_result("post_rst", base, 8'hF4, 1'b0, 2);

`ifdef CRC_STREAM_ABORT_EN
    base = seen_crc.size();
    for (int i = 0; i < 3; i++) send_beat(q9[i], 1'b0, 1'b0);
    s_abort = 1'b1;
    send_beat(8'h44, 1'b0, 1'b0);
    s_abort = 1'b0;
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_result", seen_crc.size(), base);
    @(posedge clk);
    #1;
    send_frame(q9, 1'b0, 1'b0);
    wait_seen(base + 1);
    expect_result("post_abort", base, 8'hF4, 1'b0, 2);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crc_stream_engine.md
# crc_stream_engine

Sequential, streaming CRC engine that replaces our fully unrolled frame-wide CRC divider. It accepts a frame as DATA_W-bit beats over a valid/ready handshake and runs the same MSB-first polynomial long division, one beat per cycle. It returns a CRC_BW-bit remainder per frame through an output handshake. It supports generate mode (appends CRC_BW zero bits internally) and check mode (frame already carries the received CRC; remainder must be zero). It sits between the payload framer and the link TX/RX path.

## Interface
- DATA_W, 8, bits per input beat (≥1)
- CRC_BW, 8, CRC/remainder width (≥2)
- POLY, 8'h07, generator polynomial without the implicit x^CRC_BW term
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- s_valid  input  1  input beat valid
- s_ready  output  1  engine can accept a beat
- s_data  input  DATA_W  beat data; bit DATA_W-1 is the first bit in the bit stream
- s_last  input  1  last beat of the frame
- s_mode  input  1  0 = generate, 1 = check; sampled on the first beat of a frame only
- m_valid  output  1  result valid
- m_ready  input  1  result consumer ready
- m_crc  output  CRC_BW  final remainder
- m_err  output  1  check mode: remainder ≠ 0; generate mode: always 0

## Operation
- Remainder register r is CRC_BW bits. It resets to 0 and is cleared to 0 on every return to IDLE.
- Per stream bit b: sel = r[CRC_BW-1]; r = {r[CRC_BW-2:0], b} ^ (sel ? POLY : 0). Bits are shifted MSB-first.
- Each accepted beat applies DATA_W bit steps in one cycle.
- FSM states:
  - IDLE: s_ready=1. An accepted beat latches s_mode, updates r, then goes to ACCUM, or to the end-of-frame state if s_last=1.
  - ACCUM: s_ready=1. Accepted beats update r. On an accepted beat with s_last=1, go to FLUSH in generate mode or OUT in check mode.
  - FLUSH: s_ready=0. Applies CRC_BW zero-bit steps in one cycle, then goes to OUT.
  - OUT: s_ready=0, m_valid=1. m_crc=r and m_err=(mode & (r≠0)) are held stable. When m_ready=1, go to IDLE and clear r.
- A frame may be a single beat. The frame length in bits is always a multiple of DATA_W.
- s_mode changes mid-frame are ignored.
- Idle cycles with s_valid=0 in ACCUM leave r unchanged.
- Reset mid-frame discards all state. All outputs go to their reset values immediately (asynchronous).

## Timing
- Reset values: s_ready=0 while rst_n=0, then 1 (IDLE); m_valid=0, m_crc=0, m_err=0.
- Throughput: one beat per cycle while in IDLE/ACCUM.
- Latency from the last-beat handshake at cycle T:
  - Generate: m_valid=1 from cycle T+2.
  - Check: m_valid=1 from cycle T+1.
- Output handshake completes at the rising edge where m_valid & m_ready. The next cycle has s_ready=1 and m_valid=0. There is no overlap of output and new input.
- m_valid stays high, with m_crc and m_err stable, while m_ready is low. There is no timeout.
- While s_ready=0, s_* inputs are ignored and no beat is consumed.

## Configuration
- CRC_STREAM_ABORT_EN defined:
  - Adds input s_abort (1 bit).
  - s_abort=1 in IDLE, ACCUM or FLUSH: next state is IDLE, r is cleared, and no result is produced. A beat presented in the same cycle is consumed and discarded.
  - s_abort in OUT is ignored; the result must still be handshaken.
- Macro undefined: the port is absent, and frames can only end via s_last.

## Structure
- Package crc_stream_pkg holds:
  - FSM state enum (IDLE, ACCUM, FLUSH, OUT).
  - Mode constants MODE_GEN=0 and MODE_CHK=1.
- Sub-module crc_stream_step, parameterised by STEP_W, CRC_BW and POLY. It is a purely combinational unrolled STEP_W-bit division step (r_in, bits_in → r_out).
  - Instantiated twice: STEP_W=DATA_W for beats, and STEP_W=CRC_BW with zero input for FLUSH.
- Top level holds the FSM, r, the latched mode, and the handshake logic.

## Test plan
Defaults: DATA_W=8, CRC_BW=8, POLY=8'h07.
- Generate "123456789" (0x31…0x39, last on 0x39), m_ready=1 → m_valid at T+2, m_crc=0xF4, m_err=0.
- Check 0x31…0x39,0xF4 → m_crc=0x00, m_err=0. Same frame with last byte 0xF5 → m_crc≠0, m_err=1.
- Single-beat generate: 0x01 → 0x07; 0x00 → 0x00. Back-to-back frames with s_valid held high, with s_ready low during FLUSH/OUT → each result is correct.
- Backpressure: hold m_ready=0 for 5 cycles → m_valid and m_crc stable, s_ready=0 throughout. Release → next frame is accepted the following cycle.
- Async reset asserted mid-frame, after 4 bytes → all outputs at reset values at once. Then "123456789" generate → 0xF4.
- With CRC_STREAM_ABORT_EN: abort after 3 bytes → no m_valid. Then "123456789" generate → 0xF4.
